// File: rtl/pat_tx.sv
// pat_tx: serial frame transmitter that sends a sync word, then a payload, then idle gap bits
// Ports:
//   clk    - clock, all logic on posedge
//   reset  - synchronous active-high reset, priority over everything
//   start  - frame request, accepted when start && ready
//   din    - payload, sampled only in the accept cycle
//   ready  - high in IDLE, a frame may be accepted this cycle
//   data   - registered serial line
//   valid  - high while a sync or payload bit is on data
//   sync   - high while a sync bit is on data
//   last   - high with the final payload bit
module pat_tx #(
    parameter int                  SYNC_LEN  = 8,
    parameter logic [SYNC_LEN-1:0] SYNC_WORD = SYNC_LEN'(8'b00110111),
    parameter int                  DATA_W    = 8,
    parameter int                  GAP_LEN   = 2,
    parameter logic                IDLE_BIT  = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] din,
    output logic              ready,
    output logic              data,
    output logic              valid,
    output logic              sync,
    output logic              last
);
    localparam int FW = SYNC_LEN + DATA_W;
    localparam int MX = SYNC_LEN > DATA_W ? (SYNC_LEN > GAP_LEN ? SYNC_LEN : GAP_LEN)
                                          : (DATA_W > GAP_LEN ? DATA_W : GAP_LEN);
    localparam int CW = $clog2(MX + 1);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SYNC = 2'd1;
    localparam logic [1:0] S_PAY  = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [FW-1:0] shift_q, shift_d;
    logic          data_q, data_d, valid_q, valid_d, sync_q, sync_d, last_q, last_d;
    logic          done;
    // cnt_q holds the number of bits left in the current phase, including the one on data
    assign done  = cnt_q == CW'(1);
    assign ready = state_q == S_IDLE;
    assign data  = data_q;
    assign valid = valid_q;
    assign sync  = sync_q;
    assign last  = last_q;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q;
        sync_d  = sync_q;
        last_d  = 1'b0;
        case (state_q)
            S_IDLE: if (start) begin
                state_d           = S_SYNC;
                cnt_d             = CW'(SYNC_LEN);
                // sync and payload share one shifter; first sync bit goes straight to the line
                {data_d, shift_d} = {SYNC_WORD, din, 1'b0};
                valid_d           = 1'b1;
                sync_d            = 1'b1;
            end
            S_SYNC: begin
                {data_d, shift_d} = {shift_q, 1'b0};
                state_d           = done ? S_PAY : S_SYNC;
                cnt_d             = done ? CW'(DATA_W) : cnt_q - 1'b1;
                sync_d            = !done;
                last_d            = done && DATA_W == 1;
            end
            S_PAY: if (done) begin
                state_d = GAP_LEN > 0 ? S_GAP : S_IDLE;
                cnt_d   = CW'(GAP_LEN);
                data_d  = IDLE_BIT;
                valid_d = 1'b0;
            end else begin
                {data_d, shift_d} = {shift_q, 1'b0};
                cnt_d             = cnt_q - 1'b1;
                last_d            = cnt_q == CW'(2);
            end
            default: begin
                state_d = done ? S_IDLE : S_GAP;
                cnt_d   = cnt_q - 1'b1;
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            data_q  <= IDLE_BIT;
            valid_q <= 1'b0;
            sync_q  <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            sync_q  <= sync_d;
            last_q  <= last_d;
        end
    end
endmodule

// File: tb/tb_pat_tx.sv
// tb_pat_tx: scoreboard bench for pat_tx with a reference sync detector on the line
module tb_pat_tx;
    localparam logic [7:0] SW = 8'b00110111;
    typedef struct packed {
        logic d;
        logic s;
        logic l;
    } exp_t;
    logic       clk = 1'b0, reset = 1'b1, start = 1'b0;
    logic [7:0] din = 8'h00;
    logic       ready, data, valid, sync, last;
    logic [15:0] frame_w;
    exp_t       q[$];
    exp_t       e;
    int         vec = 0, err = 0, cyc = 0, busy = 0, acc_cyc = 0, flag_cnt = 0, fc = 0;
    logic       mon_en = 1'b0, det_en = 1'b0;
    logic [7:0] det_sr = 8'h00;
    logic       det_flag = 1'b0;
    always #5 clk = ~clk;
    pat_tx dut (
        .clk(clk), .reset(reset), .start(start), .din(din),
        .ready(ready), .data(data), .valid(valid), .sync(sync), .last(last)
    );
    assign frame_w = {SW, din};
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask
    // reference model: acceptance, busy window and expected bit stream
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        det_sr   <= {det_sr[6:0], data};
        det_flag <= ({det_sr[6:0], data} == SW);
        if (reset) begin
            q.delete();
            busy <= 0;
        end else if (busy > 0) begin
            busy <= busy - 1;
        end else if (start) begin
            busy    <= 18;
            acc_cyc <= cyc;
            for (int i = 0; i < 16; i++)
                q.push_back(exp_t'{d: frame_w[15-i], s: (i < 8), l: (i == 15)});
        end
    end
    // monitor: compares every cycle's outputs against the model
    always @(negedge clk) begin
        if (mon_en) begin
            chk("ready", {31'b0, ready}, {31'b0, busy == 0});
            chk("valid", {31'b0, valid}, {31'b0, busy > 2});
            if (valid === 1'b1) begin
                if (q.size() == 0) begin
                    chk("unexpected_bit", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    chk("data", {31'b0, data}, {31'b0, e.d});
                    chk("sync", {31'b0, sync}, {31'b0, e.s});
                    chk("last", {31'b0, last}, {31'b0, e.l});
                end
            end else begin
                chk("idle_line", {29'b0, data, sync, last}, 32'b100);
            end
            if (det_en && det_flag === 1'b1) begin
                flag_cnt++;
                chk("det_cycle", cyc, acc_cyc + 9);
            end
        end
    end
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic send(input logic [7:0] v);
        start = 1'b1;
        din   = v;
        tick(1);
        start = 1'b0;
    endtask
    initial begin
        reset = 1'b1;
        start = 1'b1;
        din   = 8'h77;
        tick(1);
        mon_en = 1'b1;
        tick(1);
        reset = 1'b0;
        start = 1'b0;
        chk("rst_data", {31'b0, data}, 32'd1);
        chk("rst_valid", {31'b0, valid}, 32'd0);
        chk("rst_ready", {31'b0, ready}, 32'd1);
        chk("rst_last", {31'b0, last}, 32'd0);
        tick(2);
        det_en = 1'b1;
        fc     = flag_cnt;
        send(8'hA5);
        tick(20);
        det_en = 1'b0;
        chk("det_count", flag_cnt - fc, 32'd1);
        start = 1'b1;
        for (int i = 0; i < 57; i++) begin
            din = i[0] ? 8'h3C : 8'hC3;
            tick(1);
        end
        start = 1'b0;
        tick(20);
        send(8'h5A);
        tick(4);
        start = 1'b1;
        din   = 8'hFF;
        tick(1);
        start = 1'b0;
        tick(20);
        send(8'hC3);
        tick(11);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk("midrst_data", {31'b0, data}, 32'd1);
        chk("midrst_valid", {31'b0, valid}, 32'd0);
        chk("midrst_ready", {31'b0, ready}, 32'd1);
        tick(1);
        send(8'h0F);
        tick(20);
        chk("queue_empty", q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule
